rle_set_decoder: RTL and testbench
==================================

// Module: rle_set_decoder
// PURPOSE
// - Per-channel run-length decoder: expands 16-bit codes {count[15:8], value[7:0]} into a raster pixel stream.
// - Consumes the R/G/B code streams produced by the RLE_Set encoder; instantiate once per colour channel.
// - Regenerates the row-boundary flag (NR) and the frame-complete flag (done) from WIDTH/HEIGHT counters.
// PARAMETERS
// - WIDTH   256  pixels per row (>=2)
// - HEIGHT  256  rows per frame (>=1)
// - CNT_W   8    run-count field width (code[15:8])
// - VAL_W   8    pixel value width (code[7:0])
// PORTS
// - clk         in   1      clock, rising edge
// - rst         in   1      reset, asynchronous, active-low
// - code        in   16     RLE code {count, value}
// - code_valid  in   1      code present
// - code_ready  out  1      decoder accepts code this cycle
// - pix         out  VAL_W  decoded pixel value
// - pix_valid   out  1      pix valid
// - pix_ready   in   1      downstream accepts pix
// - NR          out  1      last pixel of current row; qualified by pix_valid
// - done        out  1      frame complete, sticky until reset
// - err         out  1      row-overrun error, sticky (RLE_DEC_ERR_EN only; else tied 0)
// BEHAVIOUR
// - Reset (rst=0, async): pix=0, pix_valid=0, NR=0, done=0, err=0; run_left, col, row cleared; any in-flight run is discarded.
// - Handshakes: code accepted when code_valid & code_ready; pixel transfers when pix_valid & pix_ready.
// - pix/pix_valid/NR held stable while pix_valid & !pix_ready.
// - code_ready = !done & (run_left==0 | (pix_valid & pix_ready & run_left==1)); back-to-back runs need no bubble.
// - States: IDLE (run_left==0, waiting) -> EXPAND (accepted count>0) -> IDLE (last pixel of run transferred, no new code) | DONE.
// - Latency: code accepted in cycle n -> pix=value, pix_valid=1 in cycle n+1; run_left loaded with count.
// - Each pixel transfer: run_left-1; col+1. At col==WIDTH-1, col wraps to 0 and row+1.
// - NR = pix_valid & (col==WIDTH-1).
// - count==0: code consumed, no pixel produced, no state change.
// - Frame end: transfer of the NR pixel while row==HEIGHT-1 -> done=1 next cycle; pix_valid=0; code_ready=0. Holds until reset.
// - Codes after done: ignored (code_ready=0).
// - Widths: run_left is CNT_W bits; col is $clog2(WIDTH) bits; row is $clog2(HEIGHT) bits; no arithmetic overflow is possible.
// - Run ending exactly on NR: normal operation, no error.
// CONFIGURATION
// - RLE_DEC_ERR_EN defined: transfer of the NR pixel with run_left>1 drops the rest of the run; run_left forced 0; err=1 sticky.
//   The next row starts from the next accepted code.
// - RLE_DEC_ERR_EN undefined: runs continue across row boundaries; NR is still asserted at each col==WIDTH-1; err tied 0.
// TESTING  (WIDTH=4, HEIGHT=2, pix_ready=1 unless stated)
// - Basic: codes 0x0305, 0x0109 back-to-back -> pix 5,5,5,9 on 4 consecutive cycles, first one cycle after accept; NR on the 9.
//   code_ready=0 for cycles 2-3 of the first run.
// - Backpressure: 0x0203 with pix_ready=1,0,0,1 -> pix=3 held through stall; exactly 2 transfers; code_ready=0 until the last transfer.
// - Zero count: 0x0000 between 0x0201 and 0x0202 -> stream 1,1,2,2; no gap pixel; NR on 4th.
// - Frame end: 0x0401, 0x0402 -> 8 pixels; NR on 4th and 8th; done=1 cycle after 8th; code_ready=0; later 0x0105 ignored, no pix_valid.
// - Overrun: 0x0607 then 0x0408.
//   With RLE_DEC_ERR_EN: 7,7,7,7 (NR), err=1, then 8,8,8,8 (NR), done.
//   Without: 7x6 then 8x2; NR on pixels 4 and 8; done; err=0.
// - Async reset: rst=0 mid-run (run_left=2) -> outputs 0 immediately without a clock edge.
//   After release, 0x0105 -> pix 5 at col 0, row 0.

Source files
------------

// File: rtl/rle_set_decoder.sv
// Per-channel run-length decoder: expands {count, value} codes into a raster pixel stream
// with row-end (NR) and frame-done flags. Define RLE_DEC_ERR_EN to truncate runs at row ends and flag err.
module rle_set_decoder #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int CNT_W  = 8,
  parameter int VAL_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W+VAL_W-1:0] code,
  input  logic                   code_valid,
  output logic                   code_ready,
  output logic [VAL_W-1:0]       pix,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   NR,
  output logic                   done,
  output logic                   err
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   run_left, run_left_n;
  logic [COL_W-1:0]   col, col_n;
  logic [ROW_W-1:0]   row, row_n;
  logic [VAL_W-1:0]   pix_n;
  logic [CNT_W-1:0]   code_cnt;
  logic [VAL_W-1:0]   code_val;
  logic               last_col, last_row, xfer, accept;

  assign code_cnt   = code[CNT_W+VAL_W-1:VAL_W];
  assign code_val   = code[VAL_W-1:0];
  assign last_col   = (col == COL_W'(WIDTH - 1));
  assign last_row   = (row == ROW_W'(HEIGHT - 1));
  assign pix_valid  = (state == EXPAND);
  assign done       = (state == DONE);
  assign NR         = pix_valid & last_col;
  assign xfer       = pix_valid & pix_ready;
  assign code_ready = !done & ((run_left == '0) | (xfer & (run_left == CNT_W'(1))));
  assign accept     = code_valid & code_ready;

`ifdef RLE_DEC_ERR_EN
  logic err_q, err_n;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    run_left_n = run_left;
    col_n      = col;
    row_n      = row;
    pix_n      = pix;
`ifdef RLE_DEC_ERR_EN
    err_n      = err_q;
`endif
    if (xfer) begin
      run_left_n = run_left - CNT_W'(1);
      if (last_col) begin
        col_n = '0;
`ifdef RLE_DEC_ERR_EN
        if (run_left > CNT_W'(1)) begin
          run_left_n = '0;
          err_n      = 1'b1;
        end
`endif
        if (last_row) begin
          state_n    = DONE;
          run_left_n = '0;
        end else begin
          row_n = row + ROW_W'(1);
        end
      end else begin
        col_n = col + COL_W'(1);
      end
      if (state_n != DONE && run_left_n == '0)
        state_n = IDLE;
    end
    // A code accepted on the final pixel of the frame is swallowed: frame end wins.
    if (accept && state_n != DONE && code_cnt != '0) begin
      run_left_n = code_cnt;
      pix_n      = code_val;
      state_n    = EXPAND;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      run_left <= '0;
      col      <= '0;
      row      <= '0;
      pix      <= '0;
`ifdef RLE_DEC_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      run_left <= run_left_n;
      col      <= col_n;
      row      <= row_n;
      pix      <= pix_n;
`ifdef RLE_DEC_ERR_EN
      err_q    <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_rle_set_decoder.sv
// Directed bench for rle_set_decoder (WIDTH=4, HEIGHT=2): queue-based pixel model checked every
// cycle, plus literal pixel-stream expectations per scenario. Honours RLE_DEC_ERR_EN when defined.
module tb_rle_set_decoder;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] code = '0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic [7:0]  pix;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        NR;
  logic        done;
  logic        err;

  rle_set_decoder #(.WIDTH(W), .HEIGHT(H), .CNT_W(8), .VAL_W(8)) dut (
    .clk(clk), .rst(rst), .code(code), .code_valid(code_valid), .code_ready(code_ready),
    .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready), .NR(NR), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the pending pixels as a plain queue, plus a count of pixels delivered this frame.
  int q[$];
  int k = 0;
  bit m_done = 0;
  bit m_err = 0;
  int cyc = 0;

  int log_val[$];
  int log_nr[$];
  int log_cyc[$];
  int acc_cyc[$];
  int done_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit e_valid();
    return !m_done && q.size() > 0;
  endfunction

  function automatic bit e_ready();
    return !m_done && (q.size() == 0 || (e_valid() && pix_ready && q.size() == 1));
  endfunction

  initial forever begin
    bit xf, acc, nr;
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      k = 0; m_done = 0; m_err = 0;
    end else begin
      cyc++;
      xf  = e_valid() && pix_ready;
      acc = code_valid && e_ready();
      if (xf) begin
        nr = (k % W) == W - 1;
        void'(q.pop_front());
        k++;
`ifdef RLE_DEC_ERR_EN
        if (nr && q.size() > 0) begin
          q.delete();
          m_err = 1;
        end
`endif
        if (k == W * H) begin
          m_done = 1;
          q.delete();
        end
      end
      if (acc && !m_done)
        for (int i = 0; i < int'(code[15:8]); i++) q.push_back(int'(code[7:0]));
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = e_valid();
    chk("pix_valid", int'(pix_valid), int'(ev));
    chk("NR", int'(NR), int'(ev && (k % W) == W - 1));
    chk("done", int'(done), int'(m_done));
    chk("err", int'(err), int'(m_err));
    chk("code_ready", int'(code_ready), int'(e_ready()));
    if (ev) chk("pix", int'(pix), q[0]);
    if (rst && pix_valid && pix_ready) begin
      log_val.push_back(int'(pix));
      log_nr.push_back(int'(NR));
      log_cyc.push_back(cyc);
    end
    if (rst && code_valid && code_ready) acc_cyc.push_back(cyc);
    if (rst && done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_val.delete(); log_nr.delete(); log_cyc.delete(); acc_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b0; code_valid = 1'b0; pix_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic send(input logic [15:0] c);
    bit ok;
    ok = 0;
    code = c;
    code_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (code_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    code_valid = 1'b0;
    chk("send_accept_timeout", int'(ok), 1);
  endtask

  task automatic check_stream(input string tag, input int ev[$], input int enr[$]);
    chk({tag, "_len"}, log_val.size(), ev.size());
    for (int i = 0; i < ev.size() && i < log_val.size(); i++) begin
      chk({tag, "_val"}, log_val[i], ev[i]);
      chk({tag, "_nr"}, log_nr[i], enr[i]);
    end
  endtask

  initial begin
    int ev[$];
    int enr[$];

    do_reset();
    chk("reset_pix", int'(pix), 0);
    chk("reset_pix_valid", int'(pix_valid), 0);
    chk("reset_done", int'(done), 0);

    // Basic back-to-back runs
    send(16'h0305);
    send(16'h0109);
    repeat (3) tick();
    ev = '{5, 5, 5, 9}; enr = '{0, 0, 0, 1};
    check_stream("basic", ev, enr);
    if (log_cyc.size() == 4 && acc_cyc.size() == 2) begin
      chk("basic_latency", log_cyc[0], acc_cyc[0] + 1);
      chk("basic_contiguous", log_cyc[3], log_cyc[0] + 3);
      chk("basic_second_accept", acc_cyc[1], acc_cyc[0] + 3);
    end else chk("basic_log_shape", log_cyc.size() * 10 + acc_cyc.size(), 42);

    // Backpressure
    do_reset();
    send(16'h0203);
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_stall_ready", int'(code_ready), 0);
    chk("bp_stall_valid", int'(pix_valid), 1);
    chk("bp_stall_pix", int'(pix), 3);
    tick();
    pix_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_ready", int'(code_ready), 1);
    repeat (3) tick();
    ev = '{3, 3}; enr = '{0, 0};
    check_stream("bp", ev, enr);
    if (log_cyc.size() == 2) chk("bp_gap", log_cyc[1], log_cyc[0] + 3);

    // Zero-count code in the middle
    do_reset();
    send(16'h0201);
    send(16'h0000);
    send(16'h0202);
    repeat (4) tick();
    ev = '{1, 1, 2, 2}; enr = '{0, 0, 0, 1};
    check_stream("zero", ev, enr);

    // Frame end and post-done codes
    do_reset();
    send(16'h0401);
    send(16'h0402);
    repeat (6) tick();
    ev = '{1, 1, 1, 1, 2, 2, 2, 2}; enr = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_stream("frame", ev, enr);
    if (log_cyc.size() == 8) chk("frame_done_cycle", done_cyc, log_cyc[7] + 1);
    chk("frame_done", int'(done), 1);
    chk("frame_ready", int'(code_ready), 0);
    code = 16'h0105;
    code_valid = 1'b1;
    repeat (5) tick();
    code_valid = 1'b0;
    chk("frame_after_done_len", log_val.size(), 8);
    chk("frame_after_done_acc", acc_cyc.size(), 2);

    // Run crossing a row boundary
    do_reset();
    send(16'h0607);
    send(16'h0408);
    repeat (12) tick();
`ifdef RLE_DEC_ERR_EN
    ev = '{7, 7, 7, 7, 8, 8, 8, 8};
    chk("overrun_err", int'(err), 1);
`else
    ev = '{7, 7, 7, 7, 7, 7, 8, 8};
    chk("overrun_err", int'(err), 0);
`endif
    enr = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_stream("overrun", ev, enr);
    chk("overrun_done", int'(done), 1);

    // Asynchronous reset mid-run
    do_reset();
    send(16'h0409);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("areset_pix_valid", int'(pix_valid), 0);
    chk("areset_pix", int'(pix), 0);
    chk("areset_NR", int'(NR), 0);
    chk("areset_done", int'(done), 0);
    chk("areset_err", int'(err), 0);
    tick();
    rst = 1'b1;
    tick();
    clear_logs();
    send(16'h0105);
    send(16'h0306);
    repeat (4) tick();
    ev = '{5, 6, 6, 6}; enr = '{0, 0, 0, 1};
    check_stream("areset", ev, enr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
